// File: rtl/silife_sync_pkg.sv
// silife grid edge-sync sequencer: shared state encoding and the
// edge length constant used by both the sequencer and silife_grid_sync.
package silife_sync_pkg;

  localparam int SYNC_CELLS = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_SHIFT,
    ST_DRAIN,
    ST_STEP
  } sync_state_t;

endpackage

// File: rtl/silife_sync_clkgen.sv
// Sync clock generator: CELLS pulses, each D+1 cycles high then
// D+1 cycles low, launched by a one-cycle start strobe.
module silife_sync_clkgen
  import silife_sync_pkg::*;
#(
  parameter int CELLS     = SYNC_CELLS,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_sync_clk,
  output logic                 o_done
);

  localparam int PW = $clog2(CELLS + 1);
  localparam logic [PW-1:0] LAST = PW'(CELLS - 1);

  logic                 run_q, run_d;
  logic                 hi_q, hi_d;
  logic [DIV_WIDTH-1:0] ph_q, ph_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic                 ph_end;
  logic                 last;

  assign ph_end = (ph_q == i_div);
  assign last   = (cnt_q == LAST);

  always_comb begin
    run_d = run_q;
    hi_d  = hi_q;
    ph_d  = ph_q;
    cnt_d = cnt_q;
    if (i_start) begin
      run_d = 1'b1;
      hi_d  = 1'b1;
      ph_d  = '0;
      cnt_d = '0;
    end else if (run_q) begin
      if (ph_end) begin
        ph_d = '0;
        if (hi_q) begin
          hi_d = 1'b0;
        end else if (last) begin
          run_d = 1'b0;
        end else begin
          hi_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      hi_q  <= 1'b0;
      ph_q  <= '0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      hi_q  <= hi_d;
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_sync_clk = hi_q;
  // done marks the final cycle of the last low phase
  assign o_done = run_q & ~hi_q & ph_end & last;

endmodule

// File: rtl/silife_sync_sequencer.sv
// Per-generation sequencer: frames the edge sync, waits for the
// shifters to drain, then pulses the grid step (or bypasses in 1-chip mode).
module silife_sync_sequencer
  import silife_sync_pkg::*;
#(
  parameter int CELLS         = SYNC_CELLS,
  parameter int DIV_WIDTH     = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_step,
  input  logic [DIV_WIDTH-1:0] i_clk_div,
  input  logic                 i_busy,
  output logic                 o_sync_clk,
  output logic                 o_sync_active,
  output logic                 o_grid_step,
  output logic                 o_ready,
  output logic                 o_timeout
);

  localparam logic [TIMEOUT_WIDTH-1:0] T_LAST = ~TIMEOUT_WIDTH'(1);

  sync_state_t              state_q, state_d;
  logic [DIV_WIDTH-1:0]     div_q;
  logic [DIV_WIDTH-1:0]     setup_q;
  logic [TIMEOUT_WIDTH-1:0] tcnt_q;
  logic                     to_q;
  logic                     setup_end;
  logic                     start;
  logic                     done;
  logic                     drain_to;
  logic                     accept;

  assign setup_end = (setup_q == div_q);
  assign start     = (state_q == ST_ACTIVE) && setup_end;
  assign drain_to  = i_busy && (tcnt_q == T_LAST);
  assign accept    = (state_q == ST_IDLE) && i_step && i_enable;

  silife_sync_clkgen #(
    .CELLS     (CELLS),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .i_div      (div_q),
    .o_sync_clk (o_sync_clk),
    .o_done     (done)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_step) state_d = i_enable ? ST_ACTIVE : ST_STEP;
      end
      ST_ACTIVE: if (setup_end) state_d = ST_SHIFT;
      ST_SHIFT:  if (done) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_busy)       state_d = ST_STEP;
        else if (drain_to) state_d = ST_IDLE;
      end
      ST_STEP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // divider and enable are frozen at accept time for the whole sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      setup_q <= '0;
      tcnt_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      if (accept) begin
        div_q <= i_clk_div;
        to_q  <= 1'b0;
      end else if (state_q == ST_DRAIN && drain_to) begin
        to_q <= 1'b1;
      end
      setup_q <= (state_q == ST_ACTIVE && !setup_end) ?
                 setup_q + 1'b1 : '0;
      tcnt_q  <= (state_q == ST_DRAIN) ? tcnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    o_sync_active = 1'b0;
    o_grid_step   = 1'b0;
    o_ready       = 1'b0;
    o_timeout     = to_q;
    unique case (state_q)
      ST_IDLE:   o_ready       = 1'b1;
      ST_ACTIVE: o_sync_active = 1'b1;
      ST_SHIFT:  o_sync_active = 1'b1;
      ST_STEP:   o_grid_step   = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_silife_sync_sequencer.sv
// Bench for silife_sync_sequencer: cycle model from the timing rules,
// directed scenarios with literal timing, then randomized traffic.
module tb_silife_sync_sequencer;

  localparam int C   = 4;
  localparam int DW  = 8;
  localparam int TW  = 4;
  localparam int TMX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_enable;
  logic          i_step;
  logic [DW-1:0] i_clk_div;
  logic          i_busy;
  logic          o_sync_clk;
  logic          o_sync_active;
  logic          o_grid_step;
  logic          o_ready;
  logic          o_timeout;

  silife_sync_sequencer #(
    .CELLS         (C),
    .DIV_WIDTH     (DW),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_step        (i_step),
    .i_clk_div     (i_clk_div),
    .i_busy        (i_busy),
    .o_sync_clk    (o_sync_clk),
    .o_sync_active (o_sync_active),
    .o_grid_step   (o_grid_step),
    .o_ready       (o_ready),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // model: 0 idle, 1 sync frame (k-th cycle), 2 drain, 3 step
  int m_mode = 0;
  int m_k    = 0;
  int m_d    = 0;
  int m_dn   = 0;
  bit m_to   = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_mode = 0;
      m_to   = 1'b0;
    end else begin
      case (m_mode)
        0: if (i_step) begin
          if (i_enable) begin
            m_mode = 1;
            m_k    = 1;
            m_d    = int'(i_clk_div);
            m_to   = 1'b0;
          end else begin
            m_mode = 3;
          end
        end
        1: if (m_k == (m_d + 1) * (2 * C + 1)) begin
          m_mode = 2;
          m_dn   = 1;
        end else begin
          m_k++;
        end
        2: if (!i_busy) m_mode = 3;
           else if (m_dn == TMX) begin
             m_mode = 0;
             m_to   = 1'b1;
           end else m_dn++;
        default: m_mode = 0;
      endcase
    end
  end

  int  n_rise = 0, n_hi = 0, n_act = 0, n_step = 0;
  int  last_step = 0;
  bit  prev_clk = 1'b0;
  bit  e_clk;

  always @(negedge clk) begin
    if (cyc > 0) begin
      e_clk = (m_mode == 1) && (m_k > m_d + 1) &&
              (((m_k - m_d - 2) / (m_d + 1)) % 2 == 0);
      chk("ready",    int'(o_ready),       int'(m_mode == 0));
      chk("active",   int'(o_sync_active), int'(m_mode == 1));
      chk("sync_clk", int'(o_sync_clk),    int'(e_clk));
      chk("step",     int'(o_grid_step),   int'(m_mode == 3));
      chk("timeout",  int'(o_timeout),     int'(m_to));
      if (o_sync_clk && !prev_clk) n_rise++;
      if (o_sync_clk) n_hi++;
      if (o_sync_active) n_act++;
      if (o_grid_step) begin
        n_step++;
        last_step = cyc;
      end
      prev_clk = o_sync_clk;
    end
  end

  int t0;
  int s_rise, s_hi, s_act, s_step;

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_rel(int r);
    while (cyc < t0 + r) cycles(1);
  endtask

  task automatic snap();
    s_rise = n_rise;
    s_hi   = n_hi;
    s_act  = n_act;
    s_step = n_step;
  endtask

  task automatic run_sync(int d);
    i_clk_div = DW'(d);
    i_enable  = 1'b1;
    i_step    = 1'b1;
    t0        = cyc;
    cycles(1);
    i_step    = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    i_enable  = 1'b0;
    i_step    = 1'b0;
    i_clk_div = '0;
    i_busy    = 1'b0;
    cycles(3);
    reset = 1'b0;
    chk("rst_ready",  int'(o_ready), 1);
    chk("rst_clk",    int'(o_sync_clk), 0);
    chk("rst_active", int'(o_sync_active), 0);
    chk("rst_to",     int'(o_timeout), 0);
    cycles(2);

    // D=0 basic sequence
    snap();
    run_sync(0);
    chk("d0_active1", int'(o_sync_active), 1);
    goto_rel(2);
    chk("d0_clk2", int'(o_sync_clk), 1);
    goto_rel(10);
    chk("d0_drain", int'(o_sync_active | o_ready), 0);
    goto_rel(11);
    chk("d0_step11", int'(o_grid_step), 1);
    goto_rel(12);
    chk("d0_ready12", int'(o_ready), 1);
    chk("d0_nact", n_act - s_act, 9);
    chk("d0_nhi", n_hi - s_hi, 4);
    chk("d0_nrise", n_rise - s_rise, 4);
    cycles(3);

    // D=2
    snap();
    run_sync(2);
    goto_rel(29);
    chk("d2_step29", int'(o_grid_step), 1);
    chk("d2_nrise", n_rise - s_rise, 4);
    chk("d2_nhi", n_hi - s_hi, 12);
    cycles(3);

    // busy for 5 drain cycles, D=1: drain starts at 19
    snap();
    i_busy = 1'b1;
    run_sync(1);
    goto_rel(24);
    chk("busy_drain24", int'(o_sync_active | o_grid_step), 0);
    i_busy = 1'b0;
    goto_rel(25);
    chk("busy_step25", int'(o_grid_step), 1);
    chk("busy_nrise", n_rise - s_rise, 4);
    cycles(3);

    // stuck busy -> timeout after 15 drain cycles
    snap();
    i_busy = 1'b1;
    run_sync(0);
    goto_rel(24);
    chk("to_drain24", int'(o_ready), 0);
    goto_rel(25);
    chk("to_flag", int'(o_timeout), 1);
    chk("to_ready", int'(o_ready), 1);
    chk("to_nostep", n_step - s_step, 0);
    i_busy = 1'b0;
    cycles(3);
    chk("to_sticky", int'(o_timeout), 1);
    run_sync(0);
    chk("to_clear", int'(o_timeout), 0);
    cycles(14);

    // bypass, step held 10 cycles
    snap();
    i_enable = 1'b0;
    i_step   = 1'b1;
    t0       = cyc;
    goto_rel(1);
    chk("byp_step1", int'(o_grid_step), 1);
    goto_rel(10);
    i_step = 1'b0;
    goto_rel(12);
    chk("byp_count", n_step - s_step, 5);
    chk("byp_last", last_step - t0, 9);
    chk("byp_noclk", n_hi - s_hi, 0);
    chk("byp_noact", n_act - s_act, 0);

    // reset mid-shift after two pulses
    run_sync(0);
    goto_rel(5);
    reset = 1'b1;
    goto_rel(6);
    chk("mid_rst_ready", int'(o_ready), 1);
    chk("mid_rst_out", int'(o_sync_clk | o_sync_active | o_grid_step), 0);
    reset = 1'b0;
    cycles(2);
    snap();
    run_sync(0);
    goto_rel(12);
    chk("mid_rst_nrise", n_rise - s_rise, 4);
    chk("mid_rst_step", last_step - t0, 11);
    cycles(2);

    // maximum divider
    snap();
    run_sync(255);
    goto_rel(256 * (2 * C + 1) + 2);
    chk("dmax_step", int'(o_grid_step), 1);
    chk("dmax_nhi", n_hi - s_hi, 4 * 256);
    cycles(2);

    // randomized traffic with mid-sequence input changes
    for (int i = 0; i < 4000; i++) begin
      i_step    = ($urandom_range(0, 3) == 0);
      i_enable  = ($urandom_range(0, 3) != 0);
      i_clk_div = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) i_busy = ~i_busy;
      reset     = ($urandom_range(0, 199) == 0);
      cycles(1);
    end
    reset  = 1'b0;
    i_step = 1'b0;
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/silife_sync_sequencer.md
# silife_sync_sequencer

Sequencer that drives the inter-chip edge synchronisation of the silife grid once per generation. It generates the sync clock and sync-active framing that `silife_grid_sync` consumes. It waits for the edge shifters to drain, then issues a one-cycle grid step to the cell array. In single-chip mode (sync disabled), step requests pass straight through to the grid.

## Interface

Parameters:
- `CELLS`, default 33: sync clock pulses per generation (edge length + corner bit).
- `DIV_WIDTH`, default 8: width of the sync clock divider setting.
- `TIMEOUT_WIDTH`, default 16: width of the drain timeout counter.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `i_enable` in 1: 1 = multi-chip sync mode; 0 = bypass.
- `i_step` in 1: request one generation; level-sampled in IDLE only.
- `i_clk_div` in DIV_WIDTH: D; each sync clock phase lasts D+1 clk cycles.
- `i_busy` in 1: OR of edge busy flags from `silife_grid_sync`.
- `o_sync_clk` out 1: sync clock to the edge shifters.
- `o_sync_active` out 1: sync frame active.
- `o_grid_step` out 1: one-cycle pulse that advances the grid.
- `o_ready` out 1: high in IDLE only.
- `o_timeout` out 1: sticky drain-timeout flag.

## Operation

- Moore FSM. All outputs decode from registered state and counters only. There is no combinational path from inputs to outputs.
- **IDLE**: `o_ready`=1.
  - `i_step`=1 and `i_enable`=1: latch D from `i_clk_div`, clear `o_timeout`, go to ACTIVE.
  - `i_step`=1 and `i_enable`=0: go to STEP.
  - `i_step` outside IDLE is ignored. There is no queueing.
- **ACTIVE**: `o_sync_active`=1 for D+1 cycles (setup), then go to SHIFT.
- **SHIFT**: `o_sync_active`=1. Emit exactly CELLS pulses on `o_sync_clk`. Each pulse is high for D+1 cycles, then low for D+1 cycles. After the last low phase, go to DRAIN.
- **DRAIN**: `o_sync_active`=0, `o_sync_clk`=0. A timeout counter increments each cycle.
  - `i_busy`=0 sampled: go to STEP.
  - Counter reaches 2^TIMEOUT_WIDTH−1 while `i_busy`=1: set `o_timeout`, go to IDLE, no step.
- **STEP**: `o_grid_step`=1 for one cycle, then go to IDLE.
- Latched D and `i_enable` are fixed for the whole sequence. Input changes mid-sequence have no effect until the next IDLE accept.
- Widths:
  - Pulse counter: $clog2(CELLS+1) bits.
  - Phase counter: DIV_WIDTH bits; wraps never, compares against latched D.
  - D=0 is legal: one-cycle phases.
  - D=2^DIV_WIDTH−1 is legal.
- `o_timeout` holds until reset or the next accepted sync-mode step.
- Reset (any state, including mid-SHIFT): next cycle IDLE, `o_sync_clk`=0, `o_sync_active`=0, `o_grid_step`=0, `o_timeout`=0, `o_ready`=1. No partial pulse is emitted.

## Timing

- Step request sampled at edge 0 (sync mode):
  - ACTIVE: cycles 1..D+1.
  - SHIFT: next 2·CELLS·(D+1) cycles, `o_sync_clk` high first in each pulse.
  - DRAIN: first cycle follows SHIFT.
  - STEP: earliest one cycle after DRAIN.
  - `o_ready`: high the cycle after STEP.
- Minimum sync-mode latency from request to `o_grid_step`: (D+1)(2·CELLS+1)+2 cycles.
- Bypass-mode latency: `o_grid_step` at cycle 1, `o_ready` again at cycle 2. Holding `i_step` high yields one step every 2 cycles.
- `i_busy` is ignored outside DRAIN.

## Structure

- Shared package `silife_sync_pkg`: FSM state encoding (IDLE, ACTIVE, SHIFT, DRAIN, STEP) and default CELLS. `silife_grid_sync` and the top level use the same CELLS constant.
- One sub-module, `silife_sync_clkgen`: phase divider plus pulse counter.
  - Inputs: start, D.
  - Outputs: `o_sync_clk`, done.
- FSM, timeout counter and output decode live in the top module.

## Test plan

- CELLS=4, D=0, `i_enable`=1, `i_busy`=0, pulse `i_step` at cycle 0:
  - `o_sync_active`=1 cycles 1–9.
  - `o_sync_clk` high at cycles 2,4,6,8.
  - DRAIN at 10, `o_grid_step` at 11, `o_ready` at 12.
- CELLS=4, D=2: exactly 4 `o_sync_clk` pulses, each 3 high + 3 low. `o_grid_step` at cycle 3+24+2=29.
- `i_busy` held 1 for 5 DRAIN cycles, then 0: `o_grid_step` exactly 1 cycle after `i_busy` falls. No extra sync pulses.
- TIMEOUT_WIDTH=4, `i_busy` stuck 1: `o_timeout` set after 15 DRAIN cycles, no `o_grid_step`, `o_ready`=1. The next accepted step clears `o_timeout`.
- `i_enable`=0, `i_step` held high 10 cycles: `o_grid_step` at cycles 1,3,5,7,9. `o_sync_clk` and `o_sync_active` stay 0.
- `reset` asserted mid-SHIFT (after 2 pulses): next cycle all outputs at reset values. A new `i_step` then produces a full CELLS-pulse sequence.
